// File: rtl/periph_pkg.sv
// periph_pkg: shared definitions for the peripheral write scheduler.
//   - address prefix field location and the well-known prefix values
//   - FSM state encoding shared by the scheduler and anything that observes it
//   - helper to extract the prefix from a 32-bit address
package periph_pkg;

  // The peripheral prefix lives in the top three address bits.
  localparam int PREFIX_MSB = 31;
  localparam int PREFIX_LSB = 29;

  // Prefix 000 is RAM (never strobes a peripheral); 001 is the first PWM slot.
  localparam logic [2:0] PREFIX_RAM  = 3'b000;
  localparam logic [2:0] PREFIX_PWM1 = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  function automatic logic [2:0] addr_prefix(input logic [31:0] addr);
    return addr[PREFIX_MSB:PREFIX_LSB];
  endfunction

endpackage

// File: rtl/periph_rr_arbiter.sv
// periph_rr_arbiter: two-requester round-robin arbiter.
//   clk, reset : clock and synchronous active-high reset
//   req0, req1 : request lines (master valid signals)
//   accept     : a granted request was taken this cycle; updates history
//   gnt0, gnt1 : combinational grants, at most one high, only for a requester
// On a tie the requester that did not win last time is granted. The history
// register resets to 1 so requester 0 wins the first tie.
module periph_rr_arbiter (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic accept,
  output logic gnt0,
  output logic gnt1
);

  logic last_grant;

  always_comb begin
    gnt0 = req0 & (~req1 | last_grant);
    gnt1 = req1 & (~req0 | ~last_grant);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= gnt1;
    end
  end

endmodule

// File: rtl/periph_write_scheduler.sv
// periph_write_scheduler: merges two write masters onto the peripheral bus.
//   clk, reset          : clock, synchronous active-high reset
//   m0_valid/addr/data  : master 0 (processor memory stage) write request
//   m0_ready            : master 0 accepted this cycle
//   m1_valid/addr/data  : master 1 (debug/loader) write request
//   m1_ready            : master 1 accepted this cycle
//   per_wr_stb          : registered one-hot strobe, bit p-1 for prefix p
//   per_wr_addr         : addr[28:0] of the issued write (bit 0 = PWM reg select)
//   per_wr_data         : data of the issued write
//   busy                : FSM not in IDLE
//   fsm_state           : current FSM state, for observation
//
// Handshake: a transfer happens in a cycle where mX_valid and mX_ready are
// both high. Masters hold valid/addr/data stable until accepted. mX_ready is
// combinational, asserted only in IDLE and only for the arbiter's grant, so
// at most one master is accepted per cycle.
//
// Each accepted write occupies one ISSUE cycle (strobe high) followed by
// GAP_CYCLES idle cycles before the next accept can happen.
import periph_pkg::*;

module periph_write_scheduler #(
  parameter int NUM_PERIPH = 7,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_valid,
  input  logic [31:0]           m0_addr,
  input  logic [31:0]           m0_data,
  output logic                  m0_ready,
  input  logic                  m1_valid,
  input  logic [31:0]           m1_addr,
  input  logic [31:0]           m1_data,
  output logic                  m1_ready,
  output logic [NUM_PERIPH-1:0] per_wr_stb,
  output logic [28:0]           per_wr_addr,
  output logic [31:0]           per_wr_data,
  output logic                  busy,
  output state_t                fsm_state
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t                state;
  logic [GAP_W-1:0]      gap_cnt;
  logic                  idle;
  logic                  gnt0;
  logic                  gnt1;
  logic                  accept;
  logic [31:0]           sel_addr;
  logic [31:0]           sel_data;
  logic [2:0]            sel_prefix;
  logic [NUM_PERIPH-1:0] stb_dec;

  assign idle      = (state == ST_IDLE);
  assign busy      = ~idle;
  assign fsm_state = state;

  periph_rr_arbiter u_arb (
    .clk    (clk),
    .reset  (reset),
    .req0   (m0_valid),
    .req1   (m1_valid),
    .accept (accept),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  assign m0_ready = idle & gnt0;
  assign m1_ready = idle & gnt1;
  assign accept   = (m0_valid & m0_ready) | (m1_valid & m1_ready);

  assign sel_addr   = gnt1 ? m1_addr : m0_addr;
  assign sel_data   = gnt1 ? m1_data : m0_data;
  assign sel_prefix = addr_prefix(sel_addr);

  // Prefix p maps to bit p-1. RAM (000) and prefixes beyond NUM_PERIPH match
  // no bit, so such writes go through the FSM but strobe nothing.
  always_comb begin
    stb_dec = '0;
    for (int i = 0; i < NUM_PERIPH; i++) begin
      stb_dec[i] = (int'(sel_prefix) == int'(PREFIX_PWM1) + i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      gap_cnt     <= '0;
      per_wr_stb  <= '0;
      per_wr_addr <= '0;
      per_wr_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            per_wr_stb  <= stb_dec;
            per_wr_addr <= sel_addr[28:0];
            per_wr_data <= sel_data;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Strobe is a single-cycle pulse; addr/data keep their value.
          per_wr_stb <= '0;
          if (GAP_CYCLES == 0) begin
            state <= ST_IDLE;
          end else begin
            state   <= ST_GAP;
            gap_cnt <= GAP_W'(GAP_CYCLES - 1);
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          state      <= ST_IDLE;
          per_wr_stb <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_periph_write_scheduler.sv
// Directed bench for periph_write_scheduler. Two instances: dut (GAP_CYCLES=1)
// and dut_g0 (GAP_CYCLES=0). Inputs change and outputs are observed on the
// falling edge; registered results of a rising edge are checked on the
// following falling edge.
import periph_pkg::*;

module tb_periph_write_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m0_data, m1_addr, m1_data;
  logic        m0_ready, m1_ready;
  logic [6:0]  per_wr_stb;
  logic [28:0] per_wr_addr;
  logic [31:0] per_wr_data;
  logic        busy;
  state_t      fsm_state;

  logic        g0_valid;
  logic [31:0] g0_addr, g0_data;
  logic        g0_ready, g0_m1_ready;
  logic [6:0]  g0_stb;
  logic [28:0] g0_wr_addr;
  logic [31:0] g0_wr_data;
  logic        g0_busy;
  state_t      g0_state;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  periph_write_scheduler #(.NUM_PERIPH(7), .GAP_CYCLES(1)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_data(m0_data), .m0_ready(m0_ready),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_data(m1_data), .m1_ready(m1_ready),
    .per_wr_stb(per_wr_stb), .per_wr_addr(per_wr_addr), .per_wr_data(per_wr_data),
    .busy(busy), .fsm_state(fsm_state)
  );

  periph_write_scheduler #(.NUM_PERIPH(7), .GAP_CYCLES(0)) dut_g0 (
    .clk(clk), .reset(reset),
    .m0_valid(g0_valid), .m0_addr(g0_addr), .m0_data(g0_data), .m0_ready(g0_ready),
    .m1_valid(1'b0), .m1_addr(32'd0), .m1_data(32'd0), .m1_ready(g0_m1_ready),
    .per_wr_stb(g0_stb), .per_wr_addr(g0_wr_addr), .per_wr_data(g0_wr_data),
    .busy(g0_busy), .fsm_state(g0_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    m0_valid = 1'b0; m0_addr = '0; m0_data = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_data = '0;
    g0_valid = 1'b0; g0_addr = '0; g0_data = '0;
    repeat (3) step();

    // Reset values
    check("rst_stb",   32'(per_wr_stb), 32'h0);
    check("rst_addr",  32'(per_wr_addr), 32'h0);
    check("rst_data",  per_wr_data, 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    check("rst_g0_stb", 32'(g0_stb), 32'h0);
    reset = 1'b0;
    step();

    // Single m0 write to PWM1, cycles-on register
    m0_valid = 1'b1; m0_addr = 32'h2000_0000; m0_data = 32'd5;
    #1;
    check("t1_m0_ready", 32'(m0_ready), 32'h1);
    check("t1_m1_ready", 32'(m1_ready), 32'h0);
    step();
    m0_valid = 1'b0;
    check("t1_stb",   32'(per_wr_stb), 32'h01);
    check("t1_addr0", 32'(per_wr_addr[0]), 32'h0);
    check("t1_data",  per_wr_data, 32'd5);
    check("t1_busy_issue", 32'(busy), 32'h1);
    check("t1_ready_issue", 32'(m0_ready), 32'h0);
    step();
    check("t1_stb_gap",  32'(per_wr_stb), 32'h0);
    check("t1_busy_gap", 32'(busy), 32'h1);
    check("t1_state_gap", 32'(fsm_state), 32'(ST_GAP));
    check("t1_data_hold", per_wr_data, 32'd5);
    step();
    check("t1_busy_idle", 32'(busy), 32'h0);

    // m1 write to RAM prefix: accepted, busy, but no strobe
    m1_valid = 1'b1; m1_addr = 32'h0000_0010; m1_data = 32'hAB;
    #1;
    check("ram_m1_ready", 32'(m1_ready), 32'h1);
    check("ram_m0_ready", 32'(m0_ready), 32'h0);
    step();
    m1_valid = 1'b0;
    check("ram_stb_issue", 32'(per_wr_stb), 32'h0);
    check("ram_busy_issue", 32'(busy), 32'h1);
    check("ram_addr", 32'(per_wr_addr), 32'h10);
    step();
    check("ram_stb_gap", 32'(per_wr_stb), 32'h0);
    check("ram_busy_gap", 32'(busy), 32'h1);
    step();
    check("ram_busy_idle", 32'(busy), 32'h0);

    // Both masters valid continuously: last grant was m1, so m0 first, then alternate
    m0_valid = 1'b1; m0_addr = 32'h2000_0004; m0_data = 32'h11;
    m1_valid = 1'b1; m1_addr = 32'h4000_0008; m1_data = 32'h22;
    for (int g = 0; g < 4; g++) begin
      #1;
      check("rr_m0_ready", 32'(m0_ready), (g % 2 == 0) ? 32'h1 : 32'h0);
      check("rr_m1_ready", 32'(m1_ready), (g % 2 == 0) ? 32'h0 : 32'h1);
      step();
      check("rr_stb",  32'(per_wr_stb), (g % 2 == 0) ? 32'h01 : 32'h02);
      check("rr_data", per_wr_data, (g % 2 == 0) ? 32'h11 : 32'h22);
      check("rr_addr", 32'(per_wr_addr), (g % 2 == 0) ? 32'h4 : 32'h8);
      step();
      check("rr_stb_gap", 32'(per_wr_stb), 32'h0);
      check("rr_no_ready_gap", 32'({m0_ready, m1_ready}), 32'h0);
      step();
    end
    m0_valid = 1'b0; m1_valid = 1'b0;
    step();
    check("rr_idle_after", 32'(busy), 32'h0);

    // m0 raises valid during ISSUE/GAP of an m1 write; waits for IDLE
    m1_valid = 1'b1; m1_addr = 32'h6000_0000; m1_data = 32'h33;
    #1;
    check("gw_m1_ready", 32'(m1_ready), 32'h1);
    step();
    m1_valid = 1'b0;
    m0_valid = 1'b1; m0_addr = 32'h2000_0002; m0_data = 32'h44;
    #1;
    check("gw_stb_p3", 32'(per_wr_stb), 32'h04);
    check("gw_m0_ready_issue", 32'(m0_ready), 32'h0);
    step();
    check("gw_m0_ready_gap", 32'(m0_ready), 32'h0);
    step();
    check("gw_m0_ready_idle", 32'(m0_ready), 32'h1);
    step();
    m0_valid = 1'b0;
    check("gw_stb", 32'(per_wr_stb), 32'h01);
    check("gw_addr", 32'(per_wr_addr), 32'h2);
    check("gw_data", per_wr_data, 32'h44);
    step();
    step();

    // Reset in the ISSUE cycle of an m0 write to PWM1 cycles-off register
    m0_valid = 1'b1; m0_addr = 32'h2000_0001; m0_data = 32'h55;
    #1;
    check("mr_m0_ready", 32'(m0_ready), 32'h1);
    step();
    m0_valid = 1'b0;
    check("mr_stb_issue", 32'(per_wr_stb), 32'h01);
    check("mr_addr0", 32'(per_wr_addr[0]), 32'h1);
    reset = 1'b1;
    step();
    check("mr_stb", 32'(per_wr_stb), 32'h0);
    check("mr_busy", 32'(busy), 32'h0);
    check("mr_state", 32'(fsm_state), 32'(ST_IDLE));
    check("mr_addr", 32'(per_wr_addr), 32'h0);
    check("mr_data", per_wr_data, 32'h0);
    reset = 1'b0;
    // Last accept was m0, but reset restores the history so m0 wins the tie
    m0_valid = 1'b1; m0_addr = 32'h2000_0000; m0_data = 32'h66;
    m1_valid = 1'b1; m1_addr = 32'h4000_0000; m1_data = 32'h77;
    #1;
    check("mr_tie_m0", 32'(m0_ready), 32'h1);
    check("mr_tie_m1", 32'(m1_ready), 32'h0);
    step();
    m0_valid = 1'b0; m1_valid = 1'b0;
    check("mr_tie_stb", 32'(per_wr_stb), 32'h01);
    check("mr_tie_data", per_wr_data, 32'h66);
    step();
    step();

    // GAP_CYCLES = 0 instance: back-to-back writes every 2 cycles
    g0_valid = 1'b1; g0_addr = 32'h4000_0000;
    for (int i = 0; i < 4; i++) begin
      g0_data = 32'(i + 1);
      #1;
      check("g0_ready_idle", 32'(g0_ready), 32'h1);
      step();
      check("g0_stb", 32'(g0_stb), 32'h02);
      check("g0_data", g0_wr_data, 32'(i + 1));
      check("g0_ready_issue", 32'(g0_ready), 32'h0);
      step();
    end
    g0_valid = 1'b0;
    check("g0_stb_after", 32'(g0_stb), 32'h0);
    check("g0_busy_after", 32'(g0_busy), 32'h0);
    step();
    check("g0_state_after", 32'(g0_state), 32'(ST_IDLE));

    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
